riscv_int_exec: RTL and testbench
=================================

Name: riscv_int_exec

Overview:
- Parametrised two-stage integer execute unit for the RISC-V core.
- Accepts RV32I OP (0x33) and OP-IMM (0x13) instructions over a valid/ready handshake, reads an internal register file, computes the result and retires it to the register file.
- Includes writeback forwarding, illegal-instruction flagging and ECALL halt.
- Sits between the fetch/decode front end and the memory/writeback logic of the core.

Parameters:
- XLEN, 32, datapath and register width; legal values 32 or 64. Shift amount uses the low log2(XLEN) bits.
- NUM_REGS, 32, architectural register count; 16 gives RV32E. Register index width is log2(NUM_REGS).
- RESET_VALUE, 0, reset contents of every register.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  in_inst is valid
- in_ready  out  1  unit accepts in_inst this cycle
- in_inst  in  32  instruction word
- out_valid  out  1  retiring result is valid
- out_ready  in  1  downstream accepts the retiring result
- out_rd_num  out  5  destination register
- out_rd_data  out  XLEN  result
- out_we  out  1  result is written to the register file on retire
- out_illegal  out  1  retiring instruction was illegal
- halted  out  1  sticky; set after ECALL retires
- dbg_num  in  5  debug read index
- dbg_data  out  XLEN  debug read data, combinational; 0 for x0

Behaviour:
- Reset (async, any time):
  - S1/S2 valid=0; halted=0; all registers=RESET_VALUE.
  - out_valid=0, out_we=0, out_illegal=0, out_rd_num=0, out_rd_data=0; in-flight instructions are dropped.
  - in_ready=1 after reset deasserts.
- Pipeline:
  - S1 captures in_inst on in_valid&&in_ready.
  - S1 decodes, reads operands and computes.
  - S2 holds the result and drives the out_* ports.
  - Latency: accept at cycle N -> out_valid at N+2 with no stall. Throughput 1/cycle.
- Handshake:
  - s2_adv = !s2_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv && !halted && !ecall_in_flight.
  - out_* hold stable while out_valid && !out_ready.
  - in_inst is ignored when in_ready=0.
- Retire: on out_valid&&out_ready, if out_we and out_rd_num!=0, write the register file that edge. x0 always reads 0; writes to x0 are discarded.
- Forwarding:
  - S1 operand rsN takes S2 out_rd_data when s2_valid && out_we && rd==rsN && rd!=0. Otherwise it takes the register file.
  - This applies while S2 is stalled as well.
- Operations:
  - OP: ADD, SUB (funct7 0x20), SLL, SLT (signed), SLTU, XOR, SRL, SRA (funct7 0x20), OR, AND.
  - OP-IMM: ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI.
  - Immediate is inst[31:20] sign-extended to XLEN. SLTIU compares against the sign-extended immediate as unsigned.
  - Arithmetic wraps modulo 2^XLEN. SLT/SLTU results are 0 or 1, zero-extended.
- Shift fields:
  - XLEN=32: SLLI/SRLI/SRAI with inst[25]=1 are illegal.
  - XLEN=64: shamt is inst[25:20].
- Illegal instructions: any other opcode, funct3/funct7 combination, or register index >= NUM_REGS. They retire with out_we=0, out_illegal=1, out_rd_data=0, and state is unchanged.
- ECALL (0x00000073):
  - Accept sets ecall_in_flight, which deasserts in_ready.
  - It retires with out_we=0, out_illegal=0.
  - halted=1 on the retire edge and stays 1 until rst; in_ready stays 0.
  - Older instructions already in S1/S2 retire normally.
- Simultaneous retire write and S1 read of the same register: forwarding supplies the new value, with no bubble.

Test Plan:
- ADDI x1,x0,5; ADDI x2,x0,-3; ADD x3,x1,x2 back-to-back, out_ready=1 -> outs 5, 0xFFFFFFFD, 2; out_valid 2 cycles after each accept; dbg x3=2.
- ADDI x1,x0,-1; SRAI x2,x1,4; SRLI x3,x1,28; SLTU x4,x0,x1; SLT x5,x1,x0 -> 0xFFFFFFFF, 0xFFFFFFFF, 0xF, 1, 1.
- ADDI x1,x0,7 then ADD x2,x1,x1 with out_ready=0 for 3 cycles -> outputs held stable, in_ready=0 after S1 fills; on release x2=14 via forwarding.
- ADDI x0,x0,9; ADD x1,x0,x0 -> first retire has rd=0 with no register change; x1=0; dbg x0=0.
- Word 0x0000707F, then SLLI with inst[25]=1 (XLEN=32) -> out_illegal=1, out_we=0, registers unchanged, next legal op executes normally.
- ADDI x1,x0,1; ECALL; ADDI x2,x0,2 offered -> x1=1 retires, halted=1 after ECALL retire, x2 never accepted; assert rst mid-stall -> all outputs 0, halted=0.

Source files
------------

// File: rtl/riscv_int_exec_if.sv
// Instruction-in / result-out handshake bundle for riscv_int_exec.
interface riscv_int_exec_if #(
  parameter int unsigned XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_inst;
  logic            out_valid;
  logic            out_ready;
  logic [4:0]      out_rd_num;
  logic [XLEN-1:0] out_rd_data;
  logic            out_we;
  logic            out_illegal;

  modport master (
    output in_valid, in_inst, out_ready,
    input  in_ready, out_valid, out_rd_num, out_rd_data, out_we, out_illegal
  );
  modport slave (
    input  in_valid, in_inst, out_ready,
    output in_ready, out_valid, out_rd_num, out_rd_data, out_we, out_illegal
  );
endinterface

// File: rtl/riscv_int_exec.sv
// Two-stage RV32I/RV64I OP/OP-IMM execute unit: S1 decodes, reads and computes;
// S2 holds the result, retires it into the register file and forwards it to S1.
module riscv_int_exec #(
  parameter int unsigned     XLEN        = 32,
  parameter int unsigned     NUM_REGS    = 32,
  parameter logic [XLEN-1:0] RESET_VALUE = '0
) (
  input  logic            clk,
  input  logic            rst,
  riscv_int_exec_if.slave bus,
  output logic            halted,
  input  logic [4:0]      dbg_num,
  output logic [XLEN-1:0] dbg_data
);
  localparam int unsigned IDX_W      = $clog2(NUM_REGS);
  localparam int unsigned SH_W       = $clog2(XLEN);
  localparam logic [6:0]  OPC_OP     = 7'h33;
  localparam logic [6:0]  OPC_OP_IMM = 7'h13;
  localparam logic [31:0] ECALL_WORD = 32'h0000_0073;

  typedef enum logic [1:0] {RUN, ECALL_PEND, HALT} run_e;

  run_e            run_q, run_d;
  logic [XLEN-1:0] regs [NUM_REGS];

  logic            s1_valid;
  logic [31:0]     s1_inst;
  logic            s2_valid, s2_we, s2_ill, s2_ecall;
  logic [4:0]      s2_rd;
  logic [XLEN-1:0] s2_data;

  logic            s1_adv, s2_adv, accept, retire;
  logic [6:0]      opc, f7;
  logic [2:0]      f3;
  logic [4:0]      rd, rs1, rs2;
  logic [XLEN-1:0] rs1_val, rs2_val, imm, op_b, sra_res, alu;
  logic [SH_W-1:0] shamt;
  logic            is_op, is_ecall, legal, shift_hi_ok;

  function automatic logic idx_ok(input logic [4:0] idx);
    return 32'(idx) < NUM_REGS;
  endfunction

  assign s2_adv       = !s2_valid || bus.out_ready;
  assign s1_adv       = !s1_valid || s2_adv;
  assign bus.in_ready = s1_adv && (run_q == RUN);
  assign accept       = bus.in_valid && bus.in_ready;
  assign retire       = s2_valid && bus.out_ready;
  assign halted       = (run_q == HALT);

  always_comb begin
    run_d = run_q;
    case (run_q)
      RUN:        if (accept && bus.in_inst == ECALL_WORD) run_d = ECALL_PEND;
      ECALL_PEND: if (retire && s2_ecall) run_d = HALT;
      default:    run_d = run_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) run_q <= RUN;
    else     run_q <= run_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_inst  <= '0;
    end else if (s1_adv) begin
      s1_valid <= accept;
      if (accept) s1_inst <= bus.in_inst;
    end
  end

  assign opc      = s1_inst[6:0];
  assign rd       = s1_inst[11:7];
  assign f3       = s1_inst[14:12];
  assign rs1      = s1_inst[19:15];
  assign rs2      = s1_inst[24:20];
  assign f7       = s1_inst[31:25];
  assign is_op    = (opc == OPC_OP);
  assign is_ecall = (s1_inst == ECALL_WORD);
  assign imm      = {{(XLEN-12){s1_inst[31]}}, s1_inst[31:20]};

  // Operand read with S2 bypass; the bypass also covers the edge where S2 retires.
  always_comb begin
    rs1_val = '0;
    rs2_val = '0;
    if (rs1 != '0) rs1_val = regs[rs1[IDX_W-1:0]];
    if (rs2 != '0) rs2_val = regs[rs2[IDX_W-1:0]];
    if (s2_valid && s2_we && s2_rd != '0 && s2_rd == rs1) rs1_val = s2_data;
    if (s2_valid && s2_we && s2_rd != '0 && s2_rd == rs2) rs2_val = s2_data;
  end

  assign op_b        = is_op ? rs2_val : imm;
  assign shamt       = is_op ? rs2_val[SH_W-1:0] : s1_inst[20 +: SH_W];
  assign shift_hi_ok = (XLEN == 64) || !s1_inst[25];
  assign sra_res     = $signed(rs1_val) >>> shamt;

  always_comb begin
    legal = 1'b0;
    if (is_op) begin
      legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101));
      legal = legal && idx_ok(rs2);
    end else if (opc == OPC_OP_IMM) begin
      case (f3)
        3'b001:  legal = (s1_inst[31:26] == 6'h00) && shift_hi_ok;
        3'b101:  legal = (s1_inst[31:26] == 6'h00 || s1_inst[31:26] == 6'h10) && shift_hi_ok;
        default: legal = 1'b1;
      endcase
    end
    legal = legal && idx_ok(rd) && idx_ok(rs1);
  end

  always_comb begin
    alu = '0;
    case (f3)
      3'b000:  alu = (is_op && s1_inst[30]) ? rs1_val - op_b : rs1_val + op_b;
      3'b001:  alu = rs1_val << shamt;
      3'b010:  alu = XLEN'($signed(rs1_val) < $signed(op_b));
      3'b011:  alu = XLEN'(rs1_val < op_b);
      3'b100:  alu = rs1_val ^ op_b;
      3'b101:  alu = s1_inst[30] ? sra_res : rs1_val >> shamt;
      3'b110:  alu = rs1_val | op_b;
      default: alu = rs1_val & op_b;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_rd    <= '0;
      s2_data  <= '0;
      s2_we    <= 1'b0;
      s2_ill   <= 1'b0;
      s2_ecall <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_rd    <= rd;
        s2_data  <= legal ? alu : '0;
        s2_we    <= legal;
        s2_ill   <= !legal && !is_ecall;
        s2_ecall <= is_ecall;
      end
    end
  end

  assign bus.out_valid   = s2_valid;
  assign bus.out_rd_num  = s2_rd;
  assign bus.out_rd_data = s2_data;
  assign bus.out_we      = s2_we;
  assign bus.out_illegal = s2_ill;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[IDX_W'(i)] <= RESET_VALUE;
    end else if (retire && s2_we && s2_rd != '0) begin
      regs[s2_rd[IDX_W-1:0]] <= s2_data;
    end
  end

  assign dbg_data = (dbg_num != '0 && idx_ok(dbg_num)) ? regs[dbg_num[IDX_W-1:0]] : '0;
endmodule

// File: tb/tb_riscv_int_exec.sv
// Bench for riscv_int_exec: directed vector table, hand-written stall/ECALL/reset
// sequences, and random traffic scored against an architectural register model.
module tb_riscv_int_exec;
  localparam int unsigned XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            halted;
  logic [4:0]      dbg_num;
  logic [XLEN-1:0] dbg_data;

  riscv_int_exec_if #(.XLEN(XLEN)) bus ();

  riscv_int_exec #(.XLEN(XLEN), .NUM_REGS(32), .RESET_VALUE(32'h0)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave),
    .halted(halted), .dbg_num(dbg_num), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        we;
    logic        ill;
    int unsigned acc;
  } exp_t;

  typedef struct {
    logic [31:0] inst;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        we;
    logic        ill;
    logic        dbg_en;
    logic [4:0]  dbg_idx;
    logic [31:0] dbg_val;
  } vec_t;

  exp_t        exp_q[$];
  exp_t        tbl_exp;
  logic [31:0] mregs [32];
  int unsigned checks = 0, failures = 0, cyc = 0, n_acc = 0;
  logic        check_lat = 1'b0, use_tbl = 1'b0, last_acc = 1'b0;
  logic        snap_valid, snap_in_ready;
  logic [4:0]  snap_rd;
  logic [31:0] snap_data;

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'h13};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Architectural model: executes in accept order, registers updated immediately.
  function automatic exp_t model_exec(input logic [31:0] inst);
    exp_t        e;
    logic [6:0]  op, f7;
    logic [2:0]  f3;
    logic [31:0] a, b, res;
    logic [4:0]  sh;
    logic        ok;
    op = inst[6:0]; f3 = inst[14:12]; f7 = inst[31:25];
    e.rd = inst[11:7]; e.data = '0; e.we = 1'b0; e.ill = 1'b0; e.acc = cyc;
    if (inst == 32'h0000_0073) return e;
    a  = mregs[inst[19:15]];
    b  = (op == 7'h33) ? mregs[inst[24:20]] : {{20{inst[31]}}, inst[31:20]};
    sh = b[4:0];
    if (op == 7'h33)      ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
    else if (op == 7'h13) ok = (f3 == 3'd1) ? (f7 == 7'h00) :
                               (f3 == 3'd5) ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
    else                  ok = 1'b0;
    if (!ok) begin
      e.ill = 1'b1;
      return e;
    end
    case (f3)
      3'd0:    res = (op == 7'h33 && f7 == 7'h20) ? a - b : a + b;
      3'd1:    res = a << sh;
      3'd2:    res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3:    res = (a < b) ? 32'd1 : 32'd0;
      3'd4:    res = a ^ b;
      3'd5:    res = (f7 == 7'h20) ? 32'($signed(a) >>> sh) : a >> sh;
      3'd6:    res = a | b;
      default: res = a & b;
    endcase
    e.we = 1'b1; e.data = res;
    if (e.rd != 5'd0) mregs[e.rd] = res;
    return e;
  endfunction

  // One clock: observe handshakes at the negedge, return 1 time unit after the posedge.
  task automatic cycle();
    exp_t e, got;
    @(negedge clk);
    last_acc      = 1'b0;
    snap_valid    = bus.out_valid;
    snap_in_ready = bus.in_ready;
    snap_rd       = bus.out_rd_num;
    snap_data     = bus.out_rd_data;
    if (bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        chk("spurious_retire", 64'(bus.out_valid), 64'(0));
      end else begin
        e = exp_q.pop_front();
        if (!e.ill) chk("ret_rd", 64'(bus.out_rd_num), 64'(e.rd));
        chk("ret_data", 64'(bus.out_rd_data), 64'(e.data));
        chk("ret_we", 64'(bus.out_we), 64'(e.we));
        chk("ret_illegal", 64'(bus.out_illegal), 64'(e.ill));
        if (check_lat) chk("latency", 64'(cyc - e.acc), 64'(2));
      end
    end
    if (bus.in_valid && bus.in_ready) begin
      got = model_exec(bus.in_inst);
      if (use_tbl) begin
        got.rd = tbl_exp.rd; got.data = tbl_exp.data; got.we = tbl_exp.we; got.ill = tbl_exp.ill;
      end
      exp_q.push_back(got);
      last_acc = 1'b1;
      n_acc++;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] inst);
    int unsigned n = 0;
    bus.in_valid = 1'b1;
    bus.in_inst  = inst;
    do begin
      cycle();
      n++;
    end while (!last_acc && n < 40);
    if (!last_acc) chk("accept_timeout", 64'(last_acc), 64'(1));
  endtask

  task automatic drain();
    int unsigned n = 0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    while ((exp_q.size() != 0 || bus.out_valid) && n < 60) begin
      cycle();
      n++;
    end
    chk("drain_empty", 64'(exp_q.size()), 64'(0));
  endtask

  task automatic dbg_chk(input string name, input logic [4:0] idx, input logic [31:0] val);
    dbg_num = idx;
    #1;
    chk(name, 64'(dbg_data), 64'(val));
  endtask

  task automatic model_reset();
    exp_q.delete();
    foreach (mregs[i]) mregs[i] = '0;
  endtask

  // Reset asserted between clock edges, checked before any edge arrives.
  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("arst_out_we", 64'(bus.out_we), 64'(0));
    chk("arst_out_illegal", 64'(bus.out_illegal), 64'(0));
    chk("arst_out_rd_num", 64'(bus.out_rd_num), 64'(0));
    chk("arst_out_rd_data", 64'(bus.out_rd_data), 64'(0));
    chk("arst_halted", 64'(halted), 64'(0));
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    #1;
    chk("arst_in_ready", 64'(bus.in_ready), 64'(1));
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] w;
    logic [2:0]  f3;
    logic [11:0] imm;
    f3 = 3'($urandom_range(0, 7));
    case ($urandom_range(0, 9))
      0, 1, 2, 3: begin
        w = enc_r(($urandom_range(0, 2) == 0) ? 7'h20 : 7'h00, 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), f3, 5'($urandom_range(0, 7)));
        if ($urandom_range(0, 15) == 0) w[25] = 1'b1;
      end
      4, 5, 6, 7, 8: begin
        imm = 12'($urandom);
        if (f3 == 3'd1 || f3 == 3'd5) begin
          imm[11:5] = ($urandom_range(0, 1) == 0) ? 7'h00 : 7'h20;
          if ($urandom_range(0, 7) == 0) imm[5] = 1'b1;
        end
        w = enc_i(imm, 5'($urandom_range(0, 7)), f3, 5'($urandom_range(0, 7)));
      end
      default: begin
        w = $urandom;
        if (w[6:0] == 7'h73) w[6:0] = 7'h7F;
      end
    endcase
    return w;
  endfunction

  vec_t tbl [16];

  initial begin
    tbl[0]  = '{enc_i(12'd5, 5'd0, 3'd0, 5'd1),      5'd1, 32'd5,         1'b1, 1'b0, 1'b0, 5'd0,  32'd0};
    tbl[1]  = '{enc_i(12'hFFD, 5'd0, 3'd0, 5'd2),    5'd2, 32'hFFFF_FFFD, 1'b1, 1'b0, 1'b0, 5'd0,  32'd0};
    tbl[2]  = '{enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3), 5'd3, 32'd2,        1'b1, 1'b0, 1'b1, 5'd3,  32'd2};
    tbl[3]  = '{enc_i(12'hFFF, 5'd0, 3'd0, 5'd1),    5'd1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 5'd0,  32'd0};
    tbl[4]  = '{enc_i(12'h404, 5'd1, 3'd5, 5'd2),    5'd2, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 5'd0,  32'd0};
    tbl[5]  = '{enc_i(12'd28, 5'd1, 3'd5, 5'd3),     5'd3, 32'h0000_000F, 1'b1, 1'b0, 1'b0, 5'd0,  32'd0};
    tbl[6]  = '{enc_r(7'h00, 5'd1, 5'd0, 3'd3, 5'd4), 5'd4, 32'd1,        1'b1, 1'b0, 1'b0, 5'd0,  32'd0};
    tbl[7]  = '{enc_r(7'h00, 5'd0, 5'd1, 3'd2, 5'd5), 5'd5, 32'd1,        1'b1, 1'b0, 1'b1, 5'd5,  32'd1};
    tbl[8]  = '{enc_i(12'd9, 5'd0, 3'd0, 5'd0),      5'd0, 32'd9,         1'b1, 1'b0, 1'b1, 5'd0,  32'd0};
    tbl[9]  = '{enc_r(7'h00, 5'd0, 5'd0, 3'd0, 5'd1), 5'd1, 32'd0,        1'b1, 1'b0, 1'b1, 5'd1,  32'd0};
    tbl[10] = '{32'h0000_707F,                       5'd0, 32'd0,         1'b0, 1'b1, 1'b0, 5'd0,  32'd0};
    tbl[11] = '{enc_i(12'h021, 5'd1, 3'd1, 5'd6),    5'd6, 32'd0,         1'b0, 1'b1, 1'b1, 5'd6,  32'd0};
    tbl[12] = '{enc_i(12'd3, 5'd6, 3'd0, 5'd7),      5'd7, 32'd3,         1'b1, 1'b0, 1'b1, 5'd7,  32'd3};
    tbl[13] = '{enc_r(7'h20, 5'd5, 5'd7, 3'd0, 5'd8), 5'd8, 32'd2,        1'b1, 1'b0, 1'b0, 5'd0,  32'd0};
    tbl[14] = '{enc_i(12'hFFF, 5'd7, 3'd3, 5'd9),    5'd9, 32'd1,         1'b1, 1'b0, 1'b0, 5'd0,  32'd0};
    tbl[15] = '{enc_i(12'h0F0, 5'd7, 3'd4, 5'd10),   5'd10, 32'h0000_00F3, 1'b1, 1'b0, 1'b1, 5'd10, 32'h0000_00F3};

    rst = 1'b1; bus.in_valid = 1'b0; bus.in_inst = '0; bus.out_ready = 1'b1; dbg_num = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 64'(bus.in_ready), 64'(1));
    chk("rst_out_rd_data", 64'(bus.out_rd_data), 64'(0));
    chk("rst_out_rd_num", 64'(bus.out_rd_num), 64'(0));
    chk("rst_out_we", 64'(bus.out_we), 64'(0));
    chk("rst_out_illegal", 64'(bus.out_illegal), 64'(0));
    chk("rst_halted", 64'(halted), 64'(0));
    dbg_chk("rst_dbg_x1", 5'd1, 32'd0);

    // Directed vectors, back-to-back except where a register readback follows.
    use_tbl = 1'b1; check_lat = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tbl_exp = '{rd: tbl[i].rd, data: tbl[i].data, we: tbl[i].we, ill: tbl[i].ill, acc: 0};
      issue(tbl[i].inst);
      if (tbl[i].dbg_en) begin
        drain();
        dbg_chk("tbl_dbg", tbl[i].dbg_idx, tbl[i].dbg_val);
      end
    end
    drain();
    use_tbl = 1'b0; check_lat = 1'b0;

    // Downstream stall: S2 holds, S1 fills, then forwarding on release.
    bus.out_ready = 1'b0;
    issue(enc_i(12'd7, 5'd0, 3'd0, 5'd1));
    issue(enc_r(7'h00, 5'd1, 5'd1, 3'd0, 5'd2));
    bus.in_valid = 1'b1;
    bus.in_inst  = enc_i(12'd1, 5'd0, 3'd0, 5'd3);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("stall_out_valid", 64'(snap_valid), 64'(1));
      chk("stall_in_ready", 64'(snap_in_ready), 64'(0));
      chk("stall_rd", 64'(snap_rd), 64'(1));
      chk("stall_data", 64'(snap_data), 64'(7));
    end
    bus.out_ready = 1'b1;
    issue(enc_i(12'd1, 5'd0, 3'd0, 5'd3));
    drain();
    dbg_chk("fwd_dbg_x2", 5'd2, 32'd14);

    // ECALL: older op retires, younger op never accepted, halt is sticky.
    issue(enc_i(12'd1, 5'd0, 3'd0, 5'd1));
    issue(32'h0000_0073);
    begin
      int unsigned acc0;
      acc0 = n_acc;
      bus.in_valid = 1'b1;
      bus.in_inst  = enc_i(12'd2, 5'd0, 3'd0, 5'd2);
      repeat (8) cycle();
      chk("ecall_no_accept", 64'(n_acc - acc0), 64'(0));
    end
    chk("ecall_halted", 64'(halted), 64'(1));
    chk("ecall_in_ready", 64'(bus.in_ready), 64'(0));
    chk("ecall_q_empty", 64'(exp_q.size()), 64'(0));
    dbg_chk("ecall_dbg_x1", 5'd1, 32'd1);
    dbg_chk("ecall_dbg_x2", 5'd2, 32'd14);
    async_reset();
    chk("post_rst_halted", 64'(halted), 64'(0));

    // Reset with a full, stalled pipeline drops both in-flight results.
    bus.out_ready = 1'b0;
    issue(enc_i(12'd5, 5'd0, 3'd0, 5'd1));
    issue(enc_i(12'd6, 5'd0, 3'd0, 5'd2));
    bus.in_valid = 1'b0;
    cycle();
    chk("flush_pre_valid", 64'(snap_valid), 64'(1));
    async_reset();
    bus.out_ready = 1'b1;
    repeat (3) cycle();
    chk("flush_no_retire", 64'(snap_valid), 64'(0));
    dbg_chk("flush_dbg_x1", 5'd1, 32'd0);

    // Random traffic with random back-pressure.
    for (int i = 0; i < 600; i++) begin
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_inst   = rand_inst();
      cycle();
    end
    drain();
    for (int r = 0; r < 32; r++) dbg_chk("rand_dbg", 5'(r), mregs[r]);
    chk("rand_halted", 64'(halted), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
